bleeper_tone: RTL
=================

// Module: bleeper_tone
// PURPOSE
//  Programmable successor to the fixed-pitch bleeper: square-wave tone generator with
//  register-set pitch, volume and optional timed duration, stopping only on a low
//  half-cycle to avoid clicks. Sits behind the PCW beeper I/O decode and feeds the audio mixer.
// PARAMETERS
//  CE_HZ       64000000  rate of ce pulses; basis for default pitch and ms tick
//  DEFAULT_HZ  4000      tone frequency after reset
//  DIV_W       16        half-period register / wr_data width
//  DUR_W       16        duration register width, units of 1 ms
//  VOL_W       8         volume / sample width
// PORTS
//  clk_sys   in   1      system clock
//  reset     in   1      synchronous, active-high reset
//  ce        in   1      clock enable; all tone/duration counting advances only on ce
//  wr        in   1      register write strobe, one clk_sys cycle, accepted regardless of ce
//  wr_addr   in   2      0=CTRL 1=HALF_PER 2=DURATION 3=VOLUME
//  wr_data   in   DIV_W  write data (CTRL: bit0 start(1)/stop(0), bit1 timed mode)
//  speaker   out  1      square wave, 0 when idle
//  sample    out  VOL_W  unsigned level: VOLUME when speaker=1, else 0
//  active    out  1      1 in PLAYING or STOPPING
// BEHAVIOUR
//  - Reset: speaker=0, sample=0, active=0, state=IDLE, HALF_PER=CE_HZ/DEFAULT_HZ/2-1,
//    DURATION=0, VOLUME=all ones, timed=0, counters=0.
//  - Half-period = HALF_PER+1 ce pulses; HALF_PER=0 gives toggle on every ce.
//  - Divider: on ce, if cnt==0 toggle wave, reload cnt<=HALF_PER; else cnt<=cnt-1.
//    HALF_PER writes take effect at next reload only (no truncated half-cycle).
//  - States: IDLE, PLAYING, STOPPING.
//    IDLE: wave=0, cnt held at 0. CTRL start -> PLAYING; first ce toggles wave to 1.
//    PLAYING: CTRL stop -> STOPPING; timed and duration expiry -> STOPPING;
//      CTRL start again -> restart duration count, wave phase kept.
//    STOPPING: keep toggling; on the toggle 1->0 (or on entry if wave already 0) -> IDLE.
//      CTRL start -> back to PLAYING, duration restarted.
//  - Duration: ms tick = one pulse every CE_HZ/1000 ce pulses, prescaler cleared on start.
//    dur_cnt<=DURATION at start; decrements per tick; expiry when tick with dur_cnt==1.
//    Timed start with DURATION=0 -> straight to STOPPING (wave 0 -> IDLE next cycle).
//    Untimed mode ignores dur_cnt.
//  - Outputs registered; speaker=wave; sample updates same cycle as speaker; VOLUME write
//    takes effect next clk_sys.
//  - Simultaneous wr and ce: register written and counters advance in the same cycle;
//    a start write wins over duration expiry in that cycle.
//  - reset mid-tone: all outputs 0 next cycle, registers to reset values.
// STRUCTURE
//  - bleeper_pkg: state enum (IDLE/PLAYING/STOPPING), register address constants,
//    CTRL bit positions.
//  - One sub-module: bleeper_prescaler (parametrised ce divider, 1-cycle tick out,
//    sync clear) generating the ms tick. Divider and FSM stay in bleeper_tone.
// TESTING (CE_HZ=8000, DEFAULT_HZ=1000 -> HALF_PER=3, ms tick every 8 ce; ce every cycle)
//  1 reset, CTRL=1 untimed -> speaker period 8 cycles, 4 high/4 low, sample 0xFF/0.
//  2 playing, HALF_PER=1 written mid-half -> current half completes at 4 ce, then 2/2.
//  3 CTRL=3 (timed), DURATION=2 -> active drops after 16 ce + end of low-going half,
//    speaker 0 at end, never truncated high pulse.
//  4 CTRL=0 while speaker=1 -> STOPPING until 1->0 toggle, then IDLE; while speaker=0 -> IDLE next cycle.
//  5 timed DURATION=0 start -> active for at most 2 cycles, speaker never 1.
//  6 reset asserted mid-high half -> speaker,sample,active 0 next cycle; restart gives default pitch.

Source files
------------

// File: rtl/bleeper_pkg.sv
// Shared definitions for the programmable bleeper: FSM states, register map
// and CTRL register bit positions.
package bleeper_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAYING,
    STOPPING
  } state_t;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_HALF_PER = 2'd1;
  localparam logic [1:0] ADDR_DURATION = 2'd2;
  localparam logic [1:0] ADDR_VOLUME   = 2'd3;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_TIMED = 1;

endpackage

// File: rtl/bleeper_prescaler.sv
// Clock-enable divider: emits a one-cycle tick on every DIV-th ce pulse.
// A synchronous clear restarts the count and masks a tick in that cycle.
module bleeper_prescaler #(
  parameter int unsigned DIV = 8
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic clear,
  input  logic ce,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = ce && !clear && (cnt == LAST);

  always_ff @(posedge clk_sys) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (ce) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bleeper_tone.sv
// Programmable square-wave tone generator with register-set pitch, volume and
// optional millisecond duration; a tone only ever ends on a low half-cycle.
module bleeper_tone
  import bleeper_pkg::*;
#(
  parameter int unsigned CE_HZ      = 64000000,
  parameter int unsigned DEFAULT_HZ = 4000,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DUR_W      = 16,
  parameter int unsigned VOL_W      = 8
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ce,
  input  logic             wr,
  input  logic [1:0]       wr_addr,
  input  logic [DIV_W-1:0] wr_data,
  output logic             speaker,
  output logic [VOL_W-1:0] sample,
  output logic             active
);

  localparam logic [DIV_W-1:0] HALF_PER_RST = DIV_W'(CE_HZ / DEFAULT_HZ / 2 - 1);
  localparam int unsigned      MS_DIV       = CE_HZ / 1000;

  state_t           state, state_nx;
  logic [DIV_W-1:0] half_per, cnt, cnt_nx;
  logic [DUR_W-1:0] duration, dur_cnt, dur_cnt_nx;
  logic [VOL_W-1:0] volume;
  logic             timed, wave, wave_nx, tick;
  logic             ctrl_wr, start, stop, start_stop, toggle, expire;

  assign ctrl_wr    = wr && (wr_addr == ADDR_CTRL);
  assign start      = ctrl_wr && wr_data[CTRL_START];
  assign stop       = ctrl_wr && !wr_data[CTRL_START];
  assign start_stop = start && wr_data[CTRL_TIMED] && (duration == '0);
  assign toggle     = ce && (state != IDLE) && (cnt == '0);
  assign expire     = (state == PLAYING) && timed && tick && (dur_cnt == DUR_W'(1));
  assign speaker    = wave;

  bleeper_prescaler #(.DIV(MS_DIV)) u_ms_tick (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clear   (start),
    .ce      (ce),
    .tick    (tick)
  );

  always_comb begin
    state_nx   = state;
    wave_nx    = wave;
    cnt_nx     = cnt;
    dur_cnt_nx = dur_cnt;

    if (state != IDLE && ce) cnt_nx = (cnt == '0) ? half_per : cnt - 1'b1;
    if (toggle) wave_nx = !wave;

    if (start) dur_cnt_nx = duration;
    else if (tick && dur_cnt != '0) dur_cnt_nx = dur_cnt - 1'b1;

    unique case (state)
      IDLE: begin
        if (start) state_nx = start_stop ? STOPPING : PLAYING;
      end
      PLAYING: begin
        if (start) state_nx = start_stop ? STOPPING : PLAYING;
        else if (stop || expire) state_nx = STOPPING;
      end
      STOPPING: begin
        if (start && !start_stop) begin
          state_nx = PLAYING;
        end else if (!wave || toggle) begin
          state_nx = IDLE;
          wave_nx  = 1'b0;
          cnt_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Never begin a new high half on the way out; the divider still reloads.
    if (state == PLAYING && state_nx == STOPPING && !wave) wave_nx = 1'b0;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      wave     <= 1'b0;
      cnt      <= '0;
      dur_cnt  <= '0;
      half_per <= HALF_PER_RST;
      duration <= '0;
      volume   <= '1;
      timed    <= 1'b0;
      sample   <= '0;
      active   <= 1'b0;
    end else begin
      state   <= state_nx;
      wave    <= wave_nx;
      cnt     <= cnt_nx;
      dur_cnt <= dur_cnt_nx;
      sample  <= wave_nx ? volume : '0;
      active  <= (state_nx != IDLE);
      if (start) timed <= wr_data[CTRL_TIMED];
      if (wr && wr_addr == ADDR_HALF_PER) half_per <= wr_data;
      if (wr && wr_addr == ADDR_DURATION) duration <= DUR_W'(wr_data);
      if (wr && wr_addr == ADDR_VOLUME)   volume   <= wr_data[VOL_W-1:0];
    end
  end

endmodule
